fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
Read-side scheduler that drains NUM_CH channel async FIFOs into one shared FIR datapath. It runs in the FIFO read-clock domain and paces transfers to a programmable sample rate. Each sample slot goes to the next non-empty channel in round-robin order. Each popped word is presented to the FIR input with a valid/ready handshake and a channel tag.

Parameters:
- WIDTH, 8, sample data width (matches FIFO WIDTH).
- NUM_CH, 2, number of channel FIFOs; legal range 2..8.
- RATE_DIV, 4, clock cycles per sample slot; legal minimum 2.

Ports:
- i_clk  in  1  FIFO read clock; the block's only clock.
- i_rst_n  in  1  reset, asynchronous assert, active low.
- i_enable  in  1  enables slot timing and new grants.
- i_rd_empty  in  NUM_CH  per-channel FIFO empty flag.
- i_fifo_data  in  NUM_CH*WIDTH  per-channel FIFO head word; channel k at bits [k*WIDTH +: WIDTH]; valid whenever that channel is not empty.
- o_rd_inc  out  NUM_CH  per-channel FIFO pop strobe, one-hot, one cycle wide.
- o_sample  out  WIDTH  sample presented to the FIR.
- o_chan  out  $clog2(NUM_CH)  channel index of o_sample.
- o_valid  out  1  o_sample/o_chan valid.
- i_ready  in  1  FIR accepts the sample.
- o_missed  out  1  sticky: a slot was lost.
- i_clr_missed  in  1  synchronous clear of o_missed.
- o_busy  out  1  high while the FSM is in S_OUT.

Behaviour:
- Reset values: all outputs 0; slot counter 0; slot_pending 0; last_grant NUM_CH-1, so channel 0 wins first; FSM in S_IDLE.
- Slot counter:
  - Counts 0..RATE_DIV-1 while i_enable=1, then wraps.
  - While i_enable=0 it is held at 0 and slot_pending is cleared.
  - At count==RATE_DIV-1 a tick occurs; the tick sets slot_pending on the next edge.
- Missed slots:
  - A tick while slot_pending is already 1 sets o_missed.
  - o_missed stays set until i_clr_missed=1.
  - If a tick and i_clr_missed occur in the same cycle, set wins.
- FSM S_IDLE:
  - If slot_pending=1, i_enable=1 and any i_rd_empty[k]=0: grant g = the first non-empty channel searching from last_grant+1 modulo NUM_CH.
  - Same edge: capture i_fifo_data[g] into o_sample and g into o_chan; set o_valid=1; set o_rd_inc[g]=1 for exactly the next cycle; last_grant<=g; slot_pending<=0; go to S_OUT.
  - If slot_pending=1 but every channel is empty, stay in S_IDLE with slot_pending kept.
- FSM S_OUT:
  - o_valid stays 1; o_sample and o_chan hold stable.
  - When i_ready=1: o_valid<=0 and return to S_IDLE.
  - Ticks keep accumulating into slot_pending and o_missed during S_OUT.
- Timing:
  - Latency from the granting edge to o_valid and o_rd_inc: 1 cycle; both are registered outputs.
  - Minimum spacing between grants: 2 cycles.
  - The FIFO pointer advances at the end of the o_rd_inc cycle. Its empty flag is therefore current before S_IDLE can re-arbitrate, so no double pop occurs.
- Deassert i_enable during S_OUT: the in-flight handshake completes; no further grants are made.
- Reset mid-operation: o_valid and o_rd_inc clear immediately. A pop pulse that had not yet reached a clock edge is dropped, and that word stays at the FIFO head.
- o_rd_inc is never asserted for an empty channel and is never multi-hot.

Decomposition:
- Package fifo_sched_pkg holds:
  - FSM state encodings S_IDLE=1'b0, S_OUT=1'b1;
  - a CH_W = $clog2(NUM_CH) helper function;
  - the RATE_DIV counter width helper.
- Sub-module rr_arbiter:
  - inputs: request vector, last_grant, strobe;
  - outputs: grant index and any_req.
  - Combinational search from last_grant+1; the pointer register stays in the parent.

Test Plan (NUM_CH=2, WIDTH=8, RATE_DIV=4):
1. Reset: assert i_rst_n=0 mid-run -> o_valid, o_rd_inc, o_missed, o_busy all 0 asynchronously; after release, first grant goes to channel 0.
2. Single channel: ch0 head=0x3C, ch1 empty, i_ready=1 -> first tick sets pending; next cycle o_valid=1, o_sample=0x3C, o_chan=0, o_rd_inc=2'b01 for exactly one cycle; ch1 never popped.
3. Round-robin: both FIFOs hold 4 words -> o_chan sequence 0,1,0,1,...; one transfer per 4 cycles; no o_missed.
4. Backpressure: i_ready=0 for 10 cycles after a grant -> o_valid, o_sample, o_chan stable. The first tick sets pending, the second sets o_missed=1. After i_ready=1, the next grant occurs 1 cycle after return to S_IDLE.
5. Starvation: both FIFOs empty for 3 ticks -> no o_rd_inc; o_missed=1 after the 2nd tick; i_clr_missed=1 clears it. Data arriving afterwards is served immediately because pending is still set.
6. Enable gating: i_enable=0 while in S_OUT with i_ready=1 -> the transfer completes, pending clears, no further o_rd_inc until i_enable=1 and the next tick.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types and width helpers for the FIFO round-robin read scheduler.
package fifo_sched_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } sched_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of the slot counter that counts 0..rate_div-1.
  function automatic int cnt_w(input int rate_div);
    return (rate_div > 1) ? $clog2(rate_div) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after last_grant.
// The grant pointer itself lives in the parent.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_grant_i,
  input  logic              strobe_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_req_o
);

  int   idx_s;
  logic found_s;

  // A grant is only meaningful while the parent strobes an arbitration.
  assign any_req_o = strobe_i & (|req_i);

  // Scan the channels in rotating order, starting just past last_grant.
  always_comb begin
    idx_s   = 0;
    found_s = 1'b0;
    grant_o = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx_s = int'(last_grant_i) + off;
      if (idx_s >= NUM_CH) begin
        idx_s = idx_s - NUM_CH;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_i[idx_s]) begin
        found_s = 1'b1;
        grant_o = CH_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Read-side scheduler: paces pops from NUM_CH channel FIFOs to one sample
// per RATE_DIV clocks, round-robin over non-empty channels, and presents
// each popped word to the FIR with a valid/ready handshake and channel tag.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_CH   = 2,
  parameter  int RATE_DIV = 4,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [NUM_CH-1:0]       i_rd_empty,
  input  logic [NUM_CH*WIDTH-1:0] i_fifo_data,
  output logic [NUM_CH-1:0]       o_rd_inc,
  output logic [WIDTH-1:0]        o_sample,
  output logic [CH_W-1:0]         o_chan,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_missed,
  input  logic                    i_clr_missed,
  output logic                    o_busy
);

  localparam int                CNT_W     = cnt_w(RATE_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(RATE_DIV - 1);
  localparam logic [CH_W-1:0]   LAST_RST  = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_CH    = {{(NUM_CH-1){1'b0}}, 1'b1};

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              missed_q, missed_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] rd_inc_q, rd_inc_d;

  logic              tick_s;
  logic              arb_strobe_s;
  logic              grant_s;
  logic [CH_W-1:0]   grant_idx_s;

  assign tick_s       = i_enable && (cnt_q == CNT_MAX);
  assign arb_strobe_s = (state_q == S_IDLE) && pending_q && i_enable;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i        (~i_rd_empty),
    .last_grant_i (last_grant_q),
    .strobe_i     (arb_strobe_s),
    .grant_o      (grant_idx_s),
    .any_req_o    (grant_s)
  );

  // Slot counter: free-runs 0..RATE_DIV-1 while enabled, parked at 0 otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_enable) begin
      cnt_d = '0;
    end else if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Slot bookkeeping: a tick opens a slot, a grant consumes it; a tick on an
  // unconsumed slot is a loss and wins over a same-cycle clear.
  always_comb begin
    pending_d = pending_q;
    missed_d  = missed_q;
    if (!i_enable) begin
      pending_d = 1'b0;
    end else if (tick_s) begin
      pending_d = 1'b1;
    end else if (grant_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (tick_s && pending_q) begin
      missed_d = 1'b1;
    end else if (i_clr_missed) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end
  end

  // Handshake FSM: capture the granted head word, pulse its pop strobe once,
  // then hold the sample until the FIR takes it.
  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    chan_d       = chan_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    rd_inc_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d      = S_OUT;
          sample_d     = i_fifo_data[int'(grant_idx_s)*WIDTH +: WIDTH];
          chan_d       = grant_idx_s;
          valid_d      = 1'b1;
          last_grant_d = grant_idx_s;
          rd_inc_d     = ONE_CH << grant_idx_s;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pop that has not yet landed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      missed_q     <= 1'b0;
      last_grant_q <= LAST_RST;
      sample_q     <= '0;
      chan_q       <= '0;
      valid_q      <= 1'b0;
      rd_inc_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      missed_q     <= missed_d;
      last_grant_q <= last_grant_d;
      sample_q     <= sample_d;
      chan_q       <= chan_d;
      valid_q      <= valid_d;
      rd_inc_q     <= rd_inc_d;
    end
  end

  assign o_rd_inc = rd_inc_q;
  assign o_sample = sample_q;
  assign o_chan   = chan_q;
  assign o_valid  = valid_q;
  assign o_missed = missed_q;
  assign o_busy   = (state_q == S_OUT);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler (NUM_CH=2, WIDTH=8, RATE_DIV=4).
// Two small FIFO models feed the DUT and pop on o_rd_inc.
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  rd_empty;
  logic [15:0] fifo_data;
  logic [1:0]  rd_inc;
  logic [7:0]  sample;
  logic [0:0]  chan;
  logic        valid;
  logic        ready;
  logic        missed;
  logic        clr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [2][16];
  int         wr_ptr [2] = '{0, 0};
  int         rd_ptr [2] = '{0, 0};
  int         pop_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  fifo_rr_scheduler #(
    .WIDTH    (8),
    .NUM_CH   (2),
    .RATE_DIV (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_rd_empty   (rd_empty),
    .i_fifo_data  (fifo_data),
    .o_rd_inc     (rd_inc),
    .o_sample     (sample),
    .o_chan       (chan),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_missed     (missed),
    .i_clr_missed (clr),
    .o_busy       (busy)
  );

  // FIFO model outputs: empty flag and head word per channel
  always_comb begin
    rd_empty  = 2'b00;
    fifo_data = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      rd_empty[k]          = (rd_ptr[k] == wr_ptr[k]);
      fifo_data[k*8 +: 8]  = mem[k][rd_ptr[k] % 16];
    end
  end

  // FIFO model pop: pointer advances at the end of the strobe cycle
  always @(posedge clk) begin
    if (rd_inc != 2'b00) begin
      checks++;
      assert ($onehot(rd_inc)) else begin
        failures++;
        $error("FAIL pop_onehot observed=%b expected=one-hot", rd_inc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rd_inc[k]) begin
        checks++;
        assert (rd_ptr[k] != wr_ptr[k]) else begin
          failures++;
          $error("FAIL pop_empty_ch%0d observed=empty expected=non-empty", k);
        end
        rd_ptr[k]  <= rd_ptr[k] + 1;
        pop_cnt[k] <= pop_cnt[k] + 1;
      end
    end
  end

  task automatic push(input int ch, input logic [7:0] d);
    mem[ch][wr_ptr[ch] % 16] = d;
    wr_ptr[ch] = wr_ptr[ch] + 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    ready  = 1'b1;
    clr    = 1'b0;
    push(0, 8'h3C);
    cyc(2);
    chk("reset_valid",  32'(valid),  32'd0);
    chk("reset_rd_inc", 32'(rd_inc), 32'd0);
    chk("reset_missed", 32'(missed), 32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_sample", 32'(sample), 32'd0);
    chk("reset_chan",   32'(chan),   32'd0);

    // Single channel: tick, pending, then grant to ch0
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(4);
    chk("single_no_early_valid", 32'(valid), 32'd0);
    cyc(1);
    chk("single_valid",  32'(valid),  32'd1);
    chk("single_sample", 32'(sample), 32'h3C);
    chk("single_chan",   32'(chan),   32'd0);
    chk("single_rd_inc", 32'(rd_inc), 32'b01);
    chk("single_busy",   32'(busy),   32'd1);
    cyc(1);
    chk("single_valid_drop", 32'(valid),  32'd0);
    chk("single_rd_inc_1cy", 32'(rd_inc), 32'b00);
    chk("single_busy_drop",  32'(busy),   32'd0);
    enable = 1'b0;
    push(0, 8'h11); push(0, 8'h12); push(0, 8'h13); push(0, 8'h14);
    push(1, 8'h21); push(1, 8'h22); push(1, 8'h23); push(1, 8'h24);
    cyc(2);

    // Grant in flight to ch1 (last grant was ch0), then reset mid-cycle
    enable = 1'b1;
    cyc(5);
    chk("pre_rst_valid",  32'(valid),  32'd1);
    chk("pre_rst_chan",   32'(chan),   32'd1);
    chk("pre_rst_rd_inc", 32'(rd_inc), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid",  32'(valid),  32'd0);
    chk("async_rst_rd_inc", 32'(rd_inc), 32'd0);
    chk("async_rst_busy",   32'(busy),   32'd0);
    chk("async_rst_missed", 32'(missed), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin after reset: ch0 first, 0x21 was not popped
    cyc(5);
    chk("rr0_valid",  32'(valid),  32'd1);
    chk("rr0_chan",   32'(chan),   32'd0);
    chk("rr0_sample", 32'(sample), 32'h11);
    chk("rr0_rd_inc", 32'(rd_inc), 32'b01);
    cyc(4);
    chk("rr1_chan",   32'(chan),   32'd1);
    chk("rr1_sample", 32'(sample), 32'h21);
    chk("rr1_rd_inc", 32'(rd_inc), 32'b10);
    cyc(4);
    chk("rr2_chan",   32'(chan),   32'd0);
    chk("rr2_sample", 32'(sample), 32'h12);
    cyc(4);
    chk("rr3_chan",   32'(chan),   32'd1);
    chk("rr3_sample", 32'(sample), 32'h22);
    chk("rr_no_missed", 32'(missed), 32'd0);

    // Backpressure for 10 cycles
    ready = 1'b0;
    cyc(3);
    chk("bp_valid",  32'(valid),  32'd1);
    chk("bp_sample", 32'(sample), 32'h22);
    chk("bp_chan",   32'(chan),   32'd1);
    chk("bp_busy",   32'(busy),   32'd1);
    chk("bp_rd_inc", 32'(rd_inc), 32'b00);
    cyc(3);
    chk("bp_missed_before_2nd_tick", 32'(missed), 32'd0);
    cyc(1);
    chk("bp_missed_set", 32'(missed), 32'd1);
    cyc(3);
    chk("bp_hold_valid",  32'(valid),  32'd1);
    chk("bp_hold_sample", 32'(sample), 32'h22);
    ready = 1'b1;
    cyc(1);
    chk("bp_release_valid", 32'(valid), 32'd0);
    chk("bp_release_busy",  32'(busy),  32'd0);
    cyc(1);
    chk("bp_next_valid",  32'(valid),  32'd1);
    chk("bp_next_chan",   32'(chan),   32'd0);
    chk("bp_next_sample", 32'(sample), 32'h13);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_missed", 32'(missed), 32'd0);
    cyc(3);
    chk("rr4_chan",   32'(chan),   32'd1);
    chk("rr4_sample", 32'(sample), 32'h23);
    cyc(4);
    chk("rr5_chan",   32'(chan),   32'd0);
    chk("rr5_sample", 32'(sample), 32'h14);
    cyc(4);
    chk("rr6_chan",   32'(chan),   32'd1);
    chk("rr6_sample", 32'(sample), 32'h24);

    // Starvation: both FIFOs now empty
    cyc(6);
    chk("starve_missed_1tick", 32'(missed), 32'd0);
    chk("starve_rd_inc_a",     32'(rd_inc), 32'b00);
    cyc(1);
    chk("starve_missed_2tick", 32'(missed), 32'd1);
    cyc(5);
    chk("starve_rd_inc_b", 32'(rd_inc), 32'b00);
    chk("starve_valid",    32'(valid),  32'd0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("starve_clr", 32'(missed), 32'd0);
    push(0, 8'h5A);
    cyc(1);
    chk("starve_serve_valid",  32'(valid),  32'd1);
    chk("starve_serve_chan",   32'(chan),   32'd0);
    chk("starve_serve_sample", 32'(sample), 32'h5A);
    chk("starve_serve_rd_inc", 32'(rd_inc), 32'b01);
    cyc(1);
    chk("starve_done_valid", 32'(valid), 32'd0);
    push(1, 8'h6B);

    // Enable gating during S_OUT
    cyc(1);
    chk("gate_valid",  32'(valid),  32'd1);
    chk("gate_chan",   32'(chan),   32'd1);
    chk("gate_sample", 32'(sample), 32'h6B);
    enable = 1'b0;
    push(0, 8'h77);
    cyc(1);
    chk("gate_complete_valid", 32'(valid), 32'd0);
    chk("gate_complete_busy",  32'(busy),  32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("gate_no_pop", 32'(rd_inc), 32'b00);
    end
    enable = 1'b1;
    cyc(4);
    chk("gate_no_early_valid", 32'(valid), 32'd0);
    cyc(1);
    chk("gate_resume_valid",  32'(valid),  32'd1);
    chk("gate_resume_chan",   32'(chan),   32'd0);
    chk("gate_resume_sample", 32'(sample), 32'h77);
    chk("gate_resume_rd_inc", 32'(rd_inc), 32'b01);
    cyc(1);
    chk("pops_ch0",   32'(pop_cnt[0]), 32'd7);
    chk("pops_ch1",   32'(pop_cnt[1]), 32'd5);
    chk("end_missed", 32'(missed),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
